uart_rx_engine: RTL
===================

# uart_rx_engine

Receive half of the full UART: the counterpart of the transmit engine behind `UART_Top`'s `tx` pin. It synchronises the asynchronous `rx` line, finds start bits, and samples data, optional parity and the stop bit at mid-bit. It presents the received byte plus parity, framing and overrun status to the UART status and data mux, using the same baud, `eight`, `p_en` and `ohel` controls as the transmitter. System clock is 100 MHz.

## Interface
- `CLK_HZ`, 100_000_000, system clock frequency the baud table is computed for.
- `clk`  in  1  system clock, rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `rx`  in  1  asynchronous serial input; idle high.
- `baud`  in  4  baud select code, indexes the shared baud table.
- `eight`  in  1  1 = 8 data bits, 0 = 7 data bits.
- `p_en`  in  1  1 = parity bit present after the data bits.
- `ohel`  in  1  parity sense: 1 = odd, 0 = even.
- `clr_rdy`  in  1  single-cycle pulse from the processor read strobe; clears `rxrdy`, `perr`, `ferr` and `ovf`.
- `rx_data`  out  8  last received character, LSB first on the line; bit 7 = 0 in 7-bit mode.
- `rxrdy`  out  1  new character available.
- `perr`  out  1  parity error on the last character.
- `ferr`  out  1  stop bit sampled low.
- `ovf`  out  1  character completed while `rxrdy` was still set.

## Operation
- `rx` passes through a 2-flop synchroniser. All logic uses the synchronised value `rxs`.
- Bit time `BT` = table[`baud`]; half time `HT` = `BT >> 1`.
- Baud table in cycles:
  - 0: 333333; 1: 83333; 2: 41667; 3: 20833; 4: 10417; 5: 5208; 6: 2604; 7: 1736; 8: 868; 9: 434; 10: 217; 11: 109.
  - Codes 12–15 map to 109.
- Frame length `N` counts the bits sampled after the start bit: `N` = 7 + `eight` + `p_en` + 1 (stop).
- FSM states:
  - IDLE: on `rxs` = 0, clear the bit-time counter and go to START.
  - START: count to `HT`-1, then sample `rxs`. If it is 1 (glitch), go to IDLE with no flag change. If it is 0, clear the counter and the bit index, then go to SHIFT.
  - SHIFT: every `BT` cycles, sample `rxs` and right-shift it into an 11-bit shift register; increment the bit index. When index = `N`-1 and that sample is taken (the stop bit), go to IDLE.
- On the stop-bit sample cycle, the following registers load and are visible the next cycle:
  - `rx_data` gets the data bits (7 or 8, zero-extended).
  - `perr` = `p_en` & (XOR(data bits, parity bit) ≠ `ohel`).
  - `ferr` = ~stop bit.
  - `ovf` = `rxrdy` (old value).
  - `rxrdy` = 1.
- Overrun overwrites `rx_data` with the new character.
- `clr_rdy` in the same cycle as a frame completion: completion wins. The flags load their new values, and `ovf` uses the pre-clear `rxrdy`.
- Returning to IDLE mid-stop-bit allows back-to-back frames without losing a start edge.
- `baud`, `eight`, `p_en` and `ohel` are sampled continuously. Changing them mid-frame is undefined; the bench changes them only in IDLE.
- Reset values:
  - FSM = IDLE, counters = 0, shift register = all ones.
  - `rx_data` = 0x00; `rxrdy`, `perr`, `ferr`, `ovf` = 0.
  - Synchroniser flops = 1.
- Reset mid-frame aborts the frame with no flag update.

## Timing
- Start-edge to first sample: 2 cycles of synchroniser delay + `HT` cycles.
- Each subsequent sample is `BT` cycles after the previous one.
- `rxrdy` rises (2 + `HT` + `N`·`BT` + 1) cycles after the falling `rx` edge.
  - For `baud`=11, 8N1: 2 + 54 + 9·109 + 1 = 1038 cycles.
- `clr_rdy` takes effect on the next edge, with 1-cycle latency.
- The bit-time counter is 19 bits wide, enough for 333333.

## Structure
- `uart_pkg`: baud-table function/constant array (shared with the transmitter), FSM state enum, `CLK_HZ`-derived constants.
- One natural sub-module: `uart_bit_timer`. It holds the 19-bit counter with a load/clear input and emits `half_tick` and `bit_tick` strobes.
- The FSM, shift register and flag logic stay in `uart_rx_engine`.

## Test plan
- `baud`=11, `eight`=1, `p_en`=0: send 0x6A (109 cycles/bit, stop=1) -> `rxrdy`=1 at cycle 1038, `rx_data`=0x6A, `perr`/`ferr`/`ovf`=0. Pulse `clr_rdy` -> `rxrdy`=0 next cycle.
- `eight`=0, `p_en`=1, `ohel`=0: send 7-bit 0x6A with parity 0 -> `rx_data`=0x6A, `perr`=0. Resend with parity 1 -> `perr`=1.
- 8N1 0x55 with stop bit driven 0 -> `rxrdy`=1, `ferr`=1, `rx_data`=0x55.
- `rx` low for 20 cycles, then high -> returns to IDLE, `rxrdy` stays 0. A following valid 0xA5 frame is received correctly.
- Two back-to-back frames, 0x12 then 0x34, without `clr_rdy` -> `rx_data`=0x34, `ovf`=1. Also, `clr_rdy` on the exact completion cycle -> `rxrdy`=1 and `ovf` reflects the old `rxrdy`.
- Assert `rst` for 1 cycle during bit 4 of a frame -> all outputs 0. The next full frame 0xC3 is received with no flags set.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions: baud-table computation, receiver FSM states and
// counter widths used by both the transmit and receive engines.
package uart_pkg;

  localparam int unsigned DEFAULT_CLK_HZ = 100_000_000;
  localparam int          CNT_W          = 19;
  localparam int          SR_W           = 11;

  typedef enum logic [1:0] {
    RX_IDLE,
    RX_START,
    RX_SHIFT
  } rx_state_e;

  function automatic int unsigned baud_rate(input int unsigned code);
    case (code)
      0:       return 300;
      1:       return 1200;
      2:       return 2400;
      3:       return 4800;
      4:       return 9600;
      5:       return 19200;
      6:       return 38400;
      7:       return 57600;
      8:       return 115200;
      9:       return 230400;
      10:      return 460800;
      default: return 921600;
    endcase
  endfunction

  // Cycles per bit, rounded to nearest; only ever evaluated at elaboration.
  function automatic logic [CNT_W-1:0] baud_cycles(input int unsigned clk_hz,
                                                   input int unsigned code);
    int unsigned rate;
    rate = baud_rate(code);
    return CNT_W'((clk_hz + rate / 2) / rate);
  endfunction

endpackage

// File: rtl/uart_bit_timer.sv
// Free-running bit-time counter with synchronous clear; flags the half-bit
// point (start-bit centring) and the full-bit point (data sampling).
module uart_bit_timer
  import uart_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic [CNT_W-1:0] bit_cycles,
  input  logic [CNT_W-1:0] half_cycles,
  output logic             half_tick,
  output logic             bit_tick
);

  logic [CNT_W-1:0] cnt;

  assign half_tick = (cnt == half_cycles - CNT_W'(1));
  assign bit_tick  = (cnt == bit_cycles - CNT_W'(1));

  // Wrapping on bit_tick keeps successive samples exactly one bit apart.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (clr || bit_tick) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/uart_rx_engine.sv
// UART receive engine: synchronises rx, centres on the start bit, samples
// data/parity/stop at mid-bit and reports the character with status flags.
module uart_rx_engine
  import uart_pkg::*;
#(
  parameter int unsigned CLK_HZ = DEFAULT_CLK_HZ
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  input  logic [3:0] baud,
  input  logic       eight,
  input  logic       p_en,
  input  logic       ohel,
  input  logic       clr_rdy,
  output logic [7:0] rx_data,
  output logic       rxrdy,
  output logic       perr,
  output logic       ferr,
  output logic       ovf
);

  logic             rx_meta;
  logic             rxs;
  rx_state_e        state;
  rx_state_e        state_nxt;
  logic [3:0]       bit_idx;
  logic [SR_W-1:0]  sr;
  logic [SR_W-1:0]  sr_next;
  logic [CNT_W-1:0] bt_table [16];
  logic [CNT_W-1:0] bt;
  logic [CNT_W-1:0] ht;
  logic             timer_clr;
  logic             half_tick;
  logic             bit_tick;
  logic             sample;
  logic             idx_clr;
  logic             done;
  logic [3:0]       frame_len;
  logic [3:0]       last_idx;
  logic [3:0]       shamt;
  logic [8:0]       frame;
  logic [7:0]       data_bits;
  logic             par_bit;
  logic             perr_nxt;

  for (genvar g = 0; g < 16; g++) begin : g_baud
    assign bt_table[g] = baud_cycles(CLK_HZ, g);
  end

  assign bt = bt_table[baud];
  assign ht = bt >> 1;

  always_ff @(posedge clk) begin
    if (rst) begin
      rx_meta <= 1'b1;
      rxs     <= 1'b1;
    end else begin
      rx_meta <= rx;
      rxs     <= rx_meta;
    end
  end

  uart_bit_timer u_timer (
    .clk         (clk),
    .rst         (rst),
    .clr         (timer_clr),
    .bit_cycles  (bt),
    .half_cycles (ht),
    .half_tick   (half_tick),
    .bit_tick    (bit_tick)
  );

  // Frame length counts every sampled bit after the start bit, stop included.
  assign frame_len = 4'd8 + {3'b000, eight} + {3'b000, p_en};
  assign last_idx  = frame_len - 4'd1;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= RX_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    timer_clr = 1'b0;
    sample    = 1'b0;
    idx_clr   = 1'b0;
    done      = 1'b0;
    case (state)
      RX_IDLE: begin
        timer_clr = 1'b1;
        if (!rxs) begin
          state_nxt = RX_START;
        end
      end
      RX_START: begin
        if (half_tick) begin
          timer_clr = 1'b1;
          if (rxs) begin
            state_nxt = RX_IDLE;
          end else begin
            idx_clr   = 1'b1;
            state_nxt = RX_SHIFT;
          end
        end
      end
      RX_SHIFT: begin
        if (bit_tick) begin
          sample = 1'b1;
          if (bit_idx == last_idx) begin
            done      = 1'b1;
            state_nxt = RX_IDLE;
          end
        end
      end
      default: state_nxt = RX_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bit_idx <= '0;
      sr      <= '1;
    end else begin
      if (idx_clr) begin
        bit_idx <= '0;
      end else if (sample) begin
        bit_idx <= bit_idx + 4'd1;
      end
      if (sample) begin
        sr <= sr_next;
      end
    end
  end

  // After the stop sample the frame sits left-justified; realign so the
  // first data bit lands in bit 0 regardless of frame length.
  assign sr_next   = {rxs, sr[SR_W-1:1]};
  assign shamt     = 4'd11 - frame_len;
  assign frame     = 9'(sr_next >> shamt);
  assign data_bits = eight ? frame[7:0] : {1'b0, frame[6:0]};
  assign par_bit   = eight ? frame[8] : frame[7];
  assign perr_nxt  = p_en & ((^data_bits ^ par_bit) != ohel);

  // A completing frame takes priority over a simultaneous read strobe.
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_data <= 8'h00;
      rxrdy   <= 1'b0;
      perr    <= 1'b0;
      ferr    <= 1'b0;
      ovf     <= 1'b0;
    end else if (done) begin
      rx_data <= data_bits;
      rxrdy   <= 1'b1;
      perr    <= perr_nxt;
      ferr    <= ~rxs;
      ovf     <= rxrdy;
    end else if (clr_rdy) begin
      rxrdy   <= 1'b0;
      perr    <= 1'b0;
      ferr    <= 1'b0;
      ovf     <= 1'b0;
    end
  end

endmodule
